// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue -- EX-stage issue unit (control side of the ALU interface).
//
// Accepts decoded operations from ID/EX over a valid/ready handshake, picks
// forwarded or register-file operands, registers them in stage A, drives the
// external combinational ALU from stage A, and captures result, branch
// decision and overflow into the stage B (EX/MEM) output register.
// Two-stage pipeline, one operation per cycle sustained.
//
// Ports:
//   CLK, nRST                 clock, synchronous active-low reset
//   in_valid / in_ready       upstream handshake
//   in_alucode                ALU operation (aluop_t)
//   in_rdat1, in_rdat2        register-file operands (rs, rt)
//   in_imm, in_alusrc         immediate and its select for operand 2
//   in_shift, in_shamt        shift form: oprnd1 = rt, oprnd2 = shamt
//   in_brtype                 00 none, 01 BEQ, 10 BNE, 11 reserved (none)
//   in_wsel, in_regwen        destination register and write enable
//   fwd1_*, fwd2_*            forwarding overrides for rs / rt
//   alu_oprnd1/2, alu_alucode to the ALU (zero while stage A is empty)
//   alu_rst, alu_*flg         from the ALU
//   out_valid / out_ready     downstream handshake
//   out_result, out_wsel, out_regwen, out_brtaken, out_ovf  stage B outputs
//
// Configuration macro: ALU_ISSUE_OVF_TRAP_EN -- when defined, an overflowing
// ADD/SUB clears out_regwen so the result is never written back.
// -----------------------------------------------------------------------------
package cpu_types_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10,
        BR_RSVD = 2'b11
    } brtype_t;
endpackage

module alu_issue
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  aluop_t            in_alucode,
    input  logic [WORD_W-1:0] in_rdat1,
    input  logic [WORD_W-1:0] in_rdat2,
    input  logic [WORD_W-1:0] in_imm,
    input  logic              in_alusrc,
    input  logic              in_shift,
    input  logic [4:0]        in_shamt,
    input  logic [1:0]        in_brtype,
    input  logic [4:0]        in_wsel,
    input  logic              in_regwen,
    input  logic              fwd1_hit,
    input  logic              fwd2_hit,
    input  logic [WORD_W-1:0] fwd1_dat,
    input  logic [WORD_W-1:0] fwd2_dat,
    output logic [WORD_W-1:0] alu_oprnd1,
    output logic [WORD_W-1:0] alu_oprnd2,
    output aluop_t            alu_alucode,
    input  logic [WORD_W-1:0] alu_rst,
    input  logic              alu_vldflg,
    input  logic              alu_cryflg,
    input  logic              alu_ngtflg,
    input  logic              alu_zroflg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_result,
    output logic [4:0]        out_wsel,
    output logic              out_regwen,
    output logic              out_brtaken,
    output logic              out_ovf
);

    // Stage A state
    logic              a_valid;
    logic [WORD_W-1:0] a_oprnd1;
    logic [WORD_W-1:0] a_oprnd2;
    aluop_t            a_alucode;
    brtype_t           a_brtype;
    logic [4:0]        a_wsel;
    logic              a_regwen;

    // Operand selection (only meaningful on the accepting edge)
    logic [WORD_W-1:0] rs_val;
    logic [WORD_W-1:0] rt_val;
    logic [WORD_W-1:0] sel_oprnd1;
    logic [WORD_W-1:0] sel_oprnd2;

    logic in_fire;
    logic b_accept;
    logic res_ovf;
    logic res_brtaken;
    logic res_regwen;

    // Carry and negative flags are not needed by the issue unit.
    logic unused_flags;
    assign unused_flags = alu_cryflg ^ alu_ngtflg;

    assign rs_val = fwd1_hit ? fwd1_dat : in_rdat1;
    assign rt_val = fwd2_hit ? fwd2_dat : in_rdat2;

    // The shift form takes priority over the immediate select.
    assign sel_oprnd1 = in_shift ? rt_val : rs_val;
    assign sel_oprnd2 = in_shift  ? {{(WORD_W-5){1'b0}}, in_shamt} :
                        in_alusrc ? in_imm : rt_val;

    // Stage B can take a new entry when empty or draining this cycle. in_ready
    // therefore depends combinationally on out_ready; the out_* outputs do not.
    assign b_accept = !out_valid || out_ready;
    assign in_ready = !a_valid || b_accept;
    assign in_fire  = in_valid && in_ready;

    // ALU inputs are quiet (zero, ALU_SLL = encoding 0) while stage A is empty.
    assign alu_oprnd1  = a_valid ? a_oprnd1 : '0;
    assign alu_oprnd2  = a_valid ? a_oprnd2 : '0;
    assign alu_alucode = a_valid ? a_alucode : ALU_SLL;

    // Overflow is only architecturally meaningful for ADD/SUB; the ALU flag is
    // masked for every other code.
    assign res_ovf = alu_vldflg && (a_alucode == ALU_ADD || a_alucode == ALU_SUB);

    // Branches rely on the decoder issuing SUB, so zero flag means equal.
    assign res_brtaken = ((a_brtype == BR_EQ) &&  alu_zroflg) ||
                         ((a_brtype == BR_NE) && !alu_zroflg);

`ifdef ALU_ISSUE_OVF_TRAP_EN
    assign res_regwen = a_regwen && !res_ovf;
`else
    assign res_regwen = a_regwen;
`endif

    // Stage A: loads on an upstream transfer, empties when drained into B.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!nRST) begin
            a_valid   <= 1'b0;
            a_oprnd1  <= '0;
            a_oprnd2  <= '0;
            a_alucode <= ALU_SLL;
            a_brtype  <= BR_NONE;
            a_wsel    <= '0;
            a_regwen  <= 1'b0;
        end else if (in_fire) begin
            a_valid   <= 1'b1;
            a_oprnd1  <= sel_oprnd1;
            a_oprnd2  <= sel_oprnd2;
            a_alucode <= in_alucode;
            a_brtype  <= brtype_t'(in_brtype);
            a_wsel    <= in_wsel;
            a_regwen  <= in_regwen;
        end else if (b_accept) begin
            a_valid   <= 1'b0;
        end
    end

    // Stage B: captures the ALU result of stage A; frozen while stalled.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_wsel    <= '0;
            out_regwen  <= 1'b0;
            out_brtaken <= 1'b0;
            out_ovf     <= 1'b0;
        end else if (b_accept) begin
            out_valid <= a_valid;
            if (a_valid) begin
                out_result  <= alu_rst;
                out_wsel    <= a_wsel;
                out_regwen  <= res_regwen;
                out_brtaken <= res_brtaken;
                out_ovf     <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue -- self-checking bench for alu_issue.
// Directed scenarios followed by a randomized stream with random backpressure.
// A behavioural ALU stands in for the real one; expected outputs come from a
// reference model that applies the operand/branch/overflow rules directly and
// a queue that tracks accepted operations in order.
// -----------------------------------------------------------------------------
module tb_alu_issue;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_valid;
    logic        in_ready;
    aluop_t      in_alucode;
    logic [31:0] in_rdat1, in_rdat2, in_imm;
    logic        in_alusrc, in_shift;
    logic [4:0]  in_shamt;
    logic [1:0]  in_brtype;
    logic [4:0]  in_wsel;
    logic        in_regwen;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_dat, fwd2_dat;
    logic [31:0] alu_oprnd1, alu_oprnd2;
    aluop_t      alu_alucode;
    logic [31:0] alu_rst;
    logic        alu_vldflg, alu_cryflg, alu_ngtflg, alu_zroflg;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_wsel;
    logic        out_regwen, out_brtaken, out_ovf;

    always #5 CLK = ~CLK;

    alu_issue #(.WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alucode(in_alucode), .in_rdat1(in_rdat1), .in_rdat2(in_rdat2),
        .in_imm(in_imm), .in_alusrc(in_alusrc), .in_shift(in_shift),
        .in_shamt(in_shamt), .in_brtype(in_brtype), .in_wsel(in_wsel),
        .in_regwen(in_regwen), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_dat(fwd1_dat), .fwd2_dat(fwd2_dat),
        .alu_oprnd1(alu_oprnd1), .alu_oprnd2(alu_oprnd2), .alu_alucode(alu_alucode),
        .alu_rst(alu_rst), .alu_vldflg(alu_vldflg), .alu_cryflg(alu_cryflg),
        .alu_ngtflg(alu_ngtflg), .alu_zroflg(alu_zroflg),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_wsel(out_wsel), .out_regwen(out_regwen), .out_brtaken(out_brtaken),
        .out_ovf(out_ovf)
    );

    typedef struct {
        aluop_t      op;
        logic [31:0] r1, r2, imm;
        logic        alusrc, shift;
        logic [4:0]  shamt;
        logic [1:0]  bt;
        logic [4:0]  wsel;
        logic        regwen;
        logic        f1hit;
        logic [31:0] f1dat;
        logic        f2hit;
        logic [31:0] f2dat;
    } op_t;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  wsel;
        logic        regwen;
        logic        brtaken;
        logic        ovf;
    } exp_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];
    op_t  cur;
    logic accepted = 1'b0;

`ifdef ALU_ISSUE_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -longint'(2147483647) - 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] alu_fn(aluop_t op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            default:  return 32'h0;
        endcase
    endfunction

    // Stand-in ALU. For codes other than ADD/SUB it raises vldflg whenever the
    // result is negative, so the issue unit's masking is exercised.
    always_comb begin
        alu_rst    = alu_fn(alu_alucode, alu_oprnd1, alu_oprnd2);
        alu_zroflg = (alu_rst == 32'h0);
        alu_ngtflg = alu_rst[31];
        alu_cryflg = 1'b0;
        case (alu_alucode)
            ALU_ADD: alu_vldflg = (alu_oprnd1[31] == alu_oprnd2[31]) && (alu_rst[31] != alu_oprnd1[31]);
            ALU_SUB: alu_vldflg = (alu_oprnd1[31] != alu_oprnd2[31]) && (alu_rst[31] != alu_oprnd1[31]);
            default: alu_vldflg = alu_rst[31];
        endcase
    end

    // Reference model: what the EX/MEM register must hold for one operation.
    function automatic exp_t ref_model(op_t o);
        exp_t        e;
        logic [31:0] rs, rt, a, b;
        longint      s;
        rs = o.f1hit ? o.f1dat : o.r1;
        rt = o.f2hit ? o.f2dat : o.r2;
        if (o.shift) begin
            a = rt;
            b = {27'b0, o.shamt};
        end else begin
            a = rs;
            b = o.alusrc ? o.imm : rt;
        end
        e.result = alu_fn(o.op, a, b);
        s = 0;
        if (o.op == ALU_ADD) s = longint'($signed(a)) + longint'($signed(b));
        if (o.op == ALU_SUB) s = longint'($signed(a)) - longint'($signed(b));
        e.ovf     = (s > SMAX) || (s < SMIN);
        e.brtaken = (o.bt == 2'b01 && e.result == 32'h0) || (o.bt == 2'b10 && e.result != 32'h0);
        e.regwen  = o.regwen && !(TRAP && e.ovf);
        e.wsel    = o.wsel;
        return e;
    endfunction

    function automatic op_t mk(aluop_t op, logic [31:0] r1, logic [31:0] r2);
        op_t o;
        o.op = op;       o.r1 = r1;        o.r2 = r2;      o.imm = 32'h0;
        o.alusrc = 1'b0; o.shift = 1'b0;   o.shamt = 5'd0; o.bt = 2'b00;
        o.wsel = 5'd1;   o.regwen = 1'b1;  o.f1hit = 1'b0; o.f1dat = 32'h0;
        o.f2hit = 1'b0;  o.f2dat = 32'h0;
        return o;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o = mk(aluop_t'($urandom_range(0, 9)), rnd_word(), rnd_word());
        o.imm    = rnd_word();
        o.alusrc = 1'($urandom_range(0, 1));
        o.shift  = ($urandom_range(0, 4) == 0);
        o.shamt  = 5'($urandom_range(0, 31));
        o.bt     = 2'($urandom_range(0, 3));
        if (o.bt != 2'b00 && $urandom_range(0, 1) == 1) o.op = ALU_SUB;
        o.wsel   = 5'($urandom_range(0, 31));
        o.regwen = 1'($urandom_range(0, 1));
        o.f1hit  = 1'($urandom_range(0, 1));
        o.f1dat  = rnd_word();
        o.f2hit  = 1'($urandom_range(0, 1));
        o.f2dat  = rnd_word();
        return o;
    endfunction

    task automatic apply(input op_t o);
        cur        = o;
        in_alucode = o.op;    in_rdat1  = o.r1;     in_rdat2  = o.r2;
        in_imm     = o.imm;   in_alusrc = o.alusrc; in_shift  = o.shift;
        in_shamt   = o.shamt; in_brtype = o.bt;     in_wsel   = o.wsel;
        in_regwen  = o.regwen;
        fwd1_hit   = o.f1hit; fwd1_dat  = o.f1dat;
        fwd2_hit   = o.f2hit; fwd2_dat  = o.f2dat;
    endtask

    task automatic edge_wait();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // One clock with scoreboard bookkeeping; inputs are already driven.
    task automatic tick();
        exp_t e;
        accepted = 1'b0;
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("sb result",  out_result,          e.result);
                check("sb wsel",    32'(out_wsel),       32'(e.wsel));
                check("sb regwen",  32'(out_regwen),     32'(e.regwen));
                check("sb brtaken", 32'(out_brtaken),    32'(e.brtaken));
                check("sb ovf",     32'(out_ovf),        32'(e.ovf));
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(ref_model(cur));
            accepted = 1'b1;
        end
        edge_wait();
    endtask

    // Directed transfer: accept on the next edge, then scramble the inputs to
    // show that only the accepting edge samples them.
    task automatic accept_one(input op_t o, input string tag);
        apply(o);
        in_valid = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        edge_wait();
        in_valid = 1'b0;
        in_rdat1 = $urandom; in_rdat2 = $urandom;
        fwd1_dat = $urandom; fwd2_dat = $urandom;
        #1;
        check({tag, " out_valid early"}, 32'(out_valid), 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res, input logic regwen,
                              input logic brtaken, input logic ovf);
        edge_wait();
        check({tag, " out_valid"},   32'(out_valid),   32'd1);
        check({tag, " out_result"},  out_result,       res);
        check({tag, " out_regwen"},  32'(out_regwen),  32'(regwen));
        check({tag, " out_brtaken"}, 32'(out_brtaken), 32'(brtaken));
        check({tag, " out_ovf"},     32'(out_ovf),     32'(ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_t o;
        op_t ops[4];
        int  sent;

        nRST      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        apply(mk(ALU_SLL, 32'h0, 32'h0));
        edge_wait();
        edge_wait();

        // Reset state
        check("rst out_valid",   32'(out_valid),   32'd0);
        check("rst out_result",  out_result,       32'd0);
        check("rst out_wsel",    32'(out_wsel),    32'd0);
        check("rst out_regwen",  32'(out_regwen),  32'd0);
        check("rst out_brtaken", 32'(out_brtaken), 32'd0);
        check("rst out_ovf",     32'(out_ovf),     32'd0);
        check("rst in_ready",    32'(in_ready),    32'd1);
        check("rst alu_oprnd1",  alu_oprnd1,       32'd0);
        check("rst alu_alucode", 32'(alu_alucode), 32'd0);
        nRST = 1'b1;

        // ADD 5 + 7, two-edge latency
        o = mk(ALU_ADD, 32'd5, 32'd7);
        o.wsel = 5'd3;
        accept_one(o, "add");
        check("add alu_oprnd1", alu_oprnd1, 32'd5);
        check("add alu_oprnd2", alu_oprnd2, 32'd7);
        check("add alu_alucode", 32'(alu_alucode), 32'(ALU_ADD));
        expect_out("add", 32'd12, 1'b1, 1'b0, 1'b0);
        check("add out_wsel", 32'(out_wsel), 32'd3);

        // Signed overflow on ADD
        accept_one(mk(ALU_ADD, 32'h7FFF_FFFF, 32'h1), "ovf");
        expect_out("ovf", 32'h8000_0000, !TRAP, 1'b0, 1'b1);

        // Shift form wins over the immediate select
        o = mk(ALU_SLL, 32'hDEAD, 32'h1);
        o.shift = 1'b1; o.shamt = 5'd4; o.alusrc = 1'b1; o.imm = 32'h99;
        accept_one(o, "sll");
        check("sll alu_oprnd1", alu_oprnd1, 32'd1);
        check("sll alu_oprnd2", alu_oprnd2, 32'd4);
        expect_out("sll", 32'h10, 1'b1, 1'b0, 1'b0);

        // Branches on equal operands
        o = mk(ALU_SUB, 32'd9, 32'd9);
        o.bt = 2'b01; o.regwen = 1'b0;
        accept_one(o, "beq");
        expect_out("beq", 32'd0, 1'b0, 1'b1, 1'b0);
        o.bt = 2'b10;
        accept_one(o, "bne");
        expect_out("bne", 32'd0, 1'b0, 1'b0, 1'b0);
        o.bt = 2'b11;
        accept_one(o, "brsvd");
        expect_out("brsvd", 32'd0, 1'b0, 1'b0, 1'b0);

        // Forwarded rs plus immediate
        o = mk(ALU_ADD, 32'd3, 32'd50);
        o.f1hit = 1'b1; o.f1dat = 32'd100; o.alusrc = 1'b1; o.imm = 32'd1;
        accept_one(o, "fwd");
        expect_out("fwd", 32'd101, 1'b1, 1'b0, 1'b0);

        // ALU overflow flag on a logical op must not reach out_ovf
        accept_one(mk(ALU_AND, 32'hF000_0000, 32'hFFFF_FFFF), "andmask");
        expect_out("andmask", 32'hF000_0000, 1'b1, 1'b0, 1'b0);
        edge_wait();

        // Four-op stream under a 3-cycle stall
        for (int k = 0; k < 4; k++) begin
            ops[k] = mk(ALU_ADD, 32'(10 * k), 32'd1);
            ops[k].wsel = 5'(k + 1);
        end
        out_ready = 1'b0;
        apply(ops[0]); in_valid = 1'b1; tick();
        apply(ops[1]); tick();
        apply(ops[2]);
        #1;
        check("stall in_ready", 32'(in_ready), 32'd0);
        check("stall out_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall hold ready",  32'(in_ready), 32'd0);
            check("stall hold result", out_result,    32'd1);
            check("stall hold wsel",   32'(out_wsel), 32'd1);
        end
        out_ready = 1'b1;
        sent = 2;
        for (int c = 0; c < 20 && (sent < 4 || q.size() != 0); c++) begin
            if (sent < 4) begin
                apply(ops[sent]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (accepted) sent++;
        end
        in_valid = 1'b0;
        check("stream accepted", 32'(sent), 32'd4);
        check("stream drained", 32'(q.size()), 32'd0);

        // Reset while stalled discards both stages
        out_ready = 1'b0;
        apply(mk(ALU_ADD, 32'd100, 32'd1)); in_valid = 1'b1; tick();
        apply(mk(ALU_ADD, 32'd200, 32'd1)); tick();
        in_valid = 1'b0;
        nRST = 1'b0;
        edge_wait();
        nRST = 1'b1;
        q.delete();
        #1;
        check("midrst out_valid",  32'(out_valid), 32'd0);
        check("midrst in_ready",   32'(in_ready),  32'd1);
        check("midrst out_result", out_result,     32'd0);
        check("midrst alu_oprnd1", alu_oprnd1,     32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();

        // Randomized stream with random backpressure
        accepted = 1'b0;
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || accepted) begin
                apply(rnd_op());
                in_valid = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) tick();
        check("random drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
